// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter / next-address sequencer for the single-cycle KGP-RISC
// datapath. Each accepted cycle it picks the next PC (sequential, PC-relative
// branch or register-indirect target), raises a one-cycle fetch-squash pulse
// on taken jumps, writes the call link, and tracks HALT / FAULT status and a
// retired-instruction counter.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   validJump    taken-jump decision for the current instruction
//   target_sel   0 = pc + sext(offset), 1 = reg_target
//   offset       26-bit signed byte offset
//   reg_target   register-sourced jump address
//   is_call      current instruction is a call (link on taken jump)
//   halt         current instruction is HALT
//   stall        current instruction not ready; hold everything
//   pc           current instruction address (registered)
//   redirect     one-cycle pulse: pc holds a jump target
//   link_we      one-cycle pulse: write link_addr to the link register
//   link_addr    return address (old pc + 4)
//   halted       sequencer is in HALT
//   fault        sequencer is in FAULT (misaligned target)
//   instr_count  retired-instruction counter
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validJump,
  input  logic        target_sel,
  input  logic [25:0] offset,
  input  logic [31:0] reg_target,
  input  logic        is_call,
  input  logic        halt,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        redirect,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        halted,
  output logic        fault,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_t;

  state_t      state_r,     state_nxt_s;
  logic [31:0] pc_r,        pc_nxt_s;
  logic        redirect_r,  redirect_nxt_s;
  logic        link_we_r,   link_we_nxt_s;
  logic [31:0] link_addr_r, link_addr_nxt_s;
  logic        halted_r,    halted_nxt_s;
  logic        fault_r,     fault_nxt_s;
  logic [31:0] count_r,     count_nxt_s;

  logic [31:0] rel_target_s;
  logic [31:0] target_s;
  logic [31:0] seq_pc_s;

  // Word alignment test for a candidate fetch address.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

  // Candidate next addresses; all arithmetic wraps modulo 2^32.
  always_comb begin
    seq_pc_s     = pc_r + 32'd4;
    rel_target_s = pc_r + {{6{offset[25]}}, offset};
    if (target_sel) begin
      target_s = reg_target;
    end else begin
      target_s = rel_target_s;
    end
  end

  // Next-state and next-output decision; pulses default low every cycle.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    redirect_nxt_s  = 1'b0;
    link_we_nxt_s   = 1'b0;
    link_addr_nxt_s = link_addr_r;
    count_nxt_s     = count_r;

    case (state_r)
      ST_RUN: begin
        if (!stall) begin
          // Every accepted instruction retires, including HALT and a faulting jump.
          count_nxt_s = count_r + 32'd1;
          if (halt) begin
            state_nxt_s = ST_HALT;
          end else if (validJump) begin
            if (!is_word_aligned(target_s)) begin
              state_nxt_s = ST_FAULT;
            end else begin
              pc_nxt_s       = target_s;
              redirect_nxt_s = 1'b1;
              if (is_call) begin
                link_we_nxt_s   = 1'b1;
                link_addr_nxt_s = seq_pc_s;
              end else begin
                link_we_nxt_s   = 1'b0;
              end
            end
          end else begin
            pc_nxt_s = seq_pc_s;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      ST_FAULT: begin
        state_nxt_s = ST_FAULT;
      end
      default: begin
        // Unreachable encoding: park in FAULT so the condition is visible.
        state_nxt_s = ST_FAULT;
      end
    endcase

    halted_nxt_s = (state_nxt_s == ST_HALT);
    fault_nxt_s  = (state_nxt_s == ST_FAULT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      redirect_r  <= 1'b0;
      link_we_r   <= 1'b0;
      link_addr_r <= 32'h0000_0000;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
      count_r     <= 32'h0000_0000;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      redirect_r  <= redirect_nxt_s;
      link_we_r   <= link_we_nxt_s;
      link_addr_r <= link_addr_nxt_s;
      halted_r    <= halted_nxt_s;
      fault_r     <= fault_nxt_s;
      count_r     <= count_nxt_s;
    end
  end

  assign pc          = pc_r;
  assign redirect    = redirect_r;
  assign link_we     = link_we_r;
  assign link_addr   = link_addr_r;
  assign halted      = halted_r;
  assign fault       = fault_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        validJump = 1'b0;
  logic        target_sel = 1'b0;
  logic [25:0] offset = 26'd0;
  logic [31:0] reg_target = 32'd0;
  logic        is_call = 1'b0;
  logic        halt = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic        redirect;
  logic        link_we;
  logic [31:0] link_addr;
  logic        halted;
  logic        fault;
  logic [31:0] instr_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_cnt = 32'd0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .validJump(validJump), .target_sel(target_sel),
    .offset(offset), .reg_target(reg_target), .is_call(is_call), .halt(halt),
    .stall(stall), .pc(pc), .redirect(redirect), .link_we(link_we),
    .link_addr(link_addr), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    validJump = 1'b0; target_sel = 1'b0; offset = 26'd0; reg_target = 32'd0;
    is_call = 1'b0; halt = 1'b0; stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (redirect !== 1'b0 || link_we !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b exp=00", redirect, link_we); end
    checks++; if (link_addr !== 32'h0) begin errors++; $display("FAIL reset_link_addr got=%h exp=0", link_addr); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_status got=%b%b exp=00", halted, fault); end
    checks++; if (instr_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", instr_count); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_cnt++;
      exp_pc = 32'd4 * i;
      checks++; if (pc !== exp_pc) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp_pc); end
    end
    checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL seq_count got=%0d exp=3", instr_count); end
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL seq_redirect got=%b exp=0", redirect); end
  endtask

  task automatic test_branch_rel();
    apply_reset();
    step(); step(); exp_cnt = 32'd2;
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL rel_setup got=%h exp=8", pc); end
    validJump = 1'b1; target_sel = 1'b0; offset = 26'h3FF_FFF8;
    step(); exp_cnt++;
    clear_inputs();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rel_pc got=%h exp=0", pc); end
    checks++; if (redirect !== 1'b1 || link_we !== 1'b0) begin errors++; $display("FAIL rel_pulses got=%b%b exp=10", redirect, link_we); end
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL rel_count got=%0d exp=%0d", instr_count, exp_cnt); end
    step(); exp_cnt++;
    checks++; if (pc !== 32'h4 || redirect !== 1'b0) begin errors++; $display("FAIL rel_after got=%h/%b exp=4/0", pc, redirect); end
  endtask

  task automatic test_call();
    step(); step(); step(); exp_cnt += 3;
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL call_setup got=%h exp=10", pc); end
    validJump = 1'b1; target_sel = 1'b1; reg_target = 32'h100; is_call = 1'b1;
    step(); exp_cnt++;
    clear_inputs();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL call_pc got=%h exp=100", pc); end
    checks++; if (link_we !== 1'b1 || redirect !== 1'b1) begin errors++; $display("FAIL call_pulses got=%b%b exp=11", link_we, redirect); end
    checks++; if (link_addr !== 32'h14) begin errors++; $display("FAIL call_link_addr got=%h exp=14", link_addr); end
    step(); exp_cnt++;
    checks++; if (pc !== 32'h104 || link_we !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL call_after got=%h/%b%b exp=104/00", pc, link_we, redirect); end
  endtask

  task automatic test_back_to_back();
    validJump = 1'b1; target_sel = 1'b0; offset = 26'h40;
    step(); exp_cnt++;
    checks++; if (pc !== 32'h144 || redirect !== 1'b1) begin errors++; $display("FAIL b2b_first got=%h/%b exp=144/1", pc, redirect); end
    step(); exp_cnt++;
    checks++; if (pc !== 32'h184 || redirect !== 1'b1) begin errors++; $display("FAIL b2b_second got=%h/%b exp=184/1", pc, redirect); end
    validJump = 1'b0; is_call = 1'b1;
    step(); exp_cnt++;
    clear_inputs();
    checks++; if (pc !== 32'h188 || link_we !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL call_not_taken got=%h/%b%b exp=188/00", pc, link_we, redirect); end
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", instr_count, exp_cnt); end
  endtask

  task automatic test_stall();
    stall = 1'b1; validJump = 1'b1; target_sel = 1'b1; reg_target = 32'h200;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (pc !== 32'h188 || instr_count !== exp_cnt || redirect !== 1'b0) begin errors++; $display("FAIL stall_hold%0d got=%h/%0d/%b exp=188/%0d/0", i, pc, instr_count, redirect, exp_cnt); end
    end
    stall = 1'b0;
    step(); exp_cnt++;
    clear_inputs();
    checks++; if (pc !== 32'h200 || redirect !== 1'b1) begin errors++; $display("FAIL stall_release got=%h/%b exp=200/1", pc, redirect); end
    checks++; if (instr_count !== exp_cnt) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", instr_count, exp_cnt); end
    stall = 1'b1; halt = 1'b1;
    step();
    clear_inputs();
    checks++; if (halted !== 1'b0 || pc !== 32'h200 || instr_count !== exp_cnt) begin errors++; $display("FAIL stall_beats_halt got=%b/%h/%0d exp=0/200/%0d", halted, pc, instr_count, exp_cnt); end
  endtask

  task automatic test_fault();
    apply_reset();
    validJump = 1'b1; target_sel = 1'b1; reg_target = 32'h102; is_call = 1'b1;
    step(); exp_cnt++;
    checks++; if (fault !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL fault_enter got=%b%b exp=10", fault, halted); end
    checks++; if (pc !== 32'h0 || link_we !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL fault_frozen got=%h/%b%b exp=0/00", pc, link_we, redirect); end
    checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL fault_count got=%0d exp=1", instr_count); end
    halt = 1'b1; reg_target = 32'h200;
    step(); step();
    checks++; if (fault !== 1'b1 || halted !== 1'b0 || pc !== 32'h0 || instr_count !== 32'd1) begin errors++; $display("FAIL fault_sticky got=%b%b/%h/%0d exp=10/0/1", fault, halted, pc, instr_count); end
    apply_reset();
    checks++; if (fault !== 1'b0 || pc !== 32'h0 || instr_count !== 32'h0) begin errors++; $display("FAIL fault_reset got=%b/%h/%0d exp=0/0/0", fault, pc, instr_count); end
    validJump = 1'b1; target_sel = 1'b0; offset = 26'h3FF_FFFE;
    step();
    clear_inputs();
    checks++; if (fault !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL fault_rel got=%b/%h exp=1/0", fault, pc); end
  endtask

  task automatic test_halt();
    apply_reset();
    for (int i = 0; i < 8; i++) step();
    exp_cnt = 32'd8;
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL halt_setup got=%h exp=20", pc); end
    halt = 1'b1; validJump = 1'b1; target_sel = 1'b1; reg_target = 32'h100; is_call = 1'b1;
    step(); exp_cnt++;
    checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL halt_enter got=%b%b exp=10", halted, fault); end
    checks++; if (pc !== 32'h20 || instr_count !== 32'd9 || redirect !== 1'b0 || link_we !== 1'b0) begin errors++; $display("FAIL halt_state got=%h/%0d/%b%b exp=20/9/00", pc, instr_count, redirect, link_we); end
    halt = 1'b0;
    step(); step();
    clear_inputs();
    checks++; if (halted !== 1'b1 || pc !== 32'h20 || instr_count !== 32'd9) begin errors++; $display("FAIL halt_sticky got=%b/%h/%0d exp=1/20/9", halted, pc, instr_count); end
  endtask

  task automatic test_wrap_and_async_reset();
    apply_reset();
    validJump = 1'b1; target_sel = 1'b1; reg_target = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
    step();
    checks++; if (pc !== 32'h0 || fault !== 1'b0) begin errors++; $display("FAIL wrap_pc got=%h/%b exp=0/0", pc, fault); end
    validJump = 1'b1; target_sel = 1'b1; reg_target = 32'h300; is_call = 1'b1;
    step();
    clear_inputs();
    checks++; if (redirect !== 1'b1 || link_we !== 1'b1 || pc !== 32'h300) begin errors++; $display("FAIL async_setup got=%b%b/%h exp=11/300", redirect, link_we, pc); end
    #2 rst = 1'b1;
    #1;
    checks++; if (redirect !== 1'b0 || link_we !== 1'b0 || pc !== 32'h0 || instr_count !== 32'h0 || link_addr !== 32'h0) begin errors++; $display("FAIL async_reset got=%b%b/%h/%0d/%h exp=00/0/0/0", redirect, link_we, pc, instr_count, link_addr); end
    #1 rst = 1'b0;
    step();
    checks++; if (pc !== 32'h4 || instr_count !== 32'd1) begin errors++; $display("FAIL post_reset got=%h/%0d exp=4/1", pc, instr_count); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_rel();
    test_call();
    test_back_to_back();
    test_stall();
    test_fault();
    test_halt();
    test_wrap_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and next-address sequencer for the single-cycle KGP-RISC datapath. It sits directly downstream of the jump-condition unit and consumes its `validJump` decision. Each accepted cycle it selects the next PC: sequential, PC-relative branch, or register-indirect target. It also produces call-link writeback, a fetch-squash pulse, halt/fault status and a retired-instruction counter.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `validJump`  in  1  taken-jump decision from the jump-condition unit for the current instruction.
- `target_sel`  in  1  0 = PC-relative target (PC + sext(offset)); 1 = register target (`reg_target`).
- `offset`  in  26  signed byte offset from the instruction word; sign-extended to 32 bits.
- `reg_target`  in  32  register-sourced jump address.
- `is_call`  in  1  current instruction is a call; link is written when the jump is taken.
- `halt`  in  1  current instruction is HALT.
- `stall`  in  1  current instruction is not yet ready; hold all state.
- `pc`  out  32  current instruction address (registered).
- `redirect`  out  1  registered one-cycle pulse: `pc` now holds a jump target; fetch squashes.
- `link_we`  out  1  registered one-cycle pulse: write `link_addr` to the link register.
- `link_addr`  out  32  return address (old PC + 4), valid while `link_we`=1.
- `halted`  out  1  sequencer is in HALT.
- `fault`  out  1  sequencer is in FAULT (misaligned target).
- `instr_count`  out  32  retired-instruction counter.

## Operation
- States: RUN, HALT, FAULT. Reset enters RUN.
- Reset values: `pc`=RESET_PC, `redirect`=0, `link_we`=0, `link_addr`=0, `halted`=0, `fault`=0, `instr_count`=0.
- An instruction is accepted in a cycle when state=RUN and `stall`=0. Only accepted instructions change state.
- Priority within an accepted cycle:
  - `halt`=1: go to HALT; `pc` holds its value; `validJump` and `is_call` are ignored.
  - Else, `validJump`=1:
    - target = `target_sel` ? `reg_target` : `pc` + sext(`offset`), computed modulo 2^32.
    - If target[1:0]≠0, go to FAULT, `pc` holds, and no link is written.
    - Otherwise `pc`←target and `redirect` pulses. If `is_call`=1, `link_we` pulses with `link_addr`=old `pc`+4.
  - Else: `pc`←`pc`+4, wrapping at 2^32 with no error.
- `is_call`=1 with `validJump`=0: no link write.
- `instr_count` increments by 1 on every accepted instruction, including HALT and the faulting jump. It wraps 2^32−1→0.
- HALT and FAULT are sticky. Only `rst` leaves them. All inputs are ignored, `pc` and `instr_count` are frozen, and `redirect`/`link_we` are 0.
- `halted`=1 exactly in HALT; `fault`=1 exactly in FAULT.
- While stalled, `pc`, `instr_count` and state hold, and `redirect`/`link_we` are 0 on the following cycle.

## Timing
- All outputs are registered and change only on a rising `clk` edge or on `rst`.
- Next-PC latency is 1 cycle: the decision taken in cycle N is visible on `pc` in cycle N+1.
- `redirect`/`link_we` are high only in cycle N+1 for a taken jump accepted in cycle N. Back-to-back taken jumps produce back-to-back pulses.
- `rst` asserted mid-operation immediately (asynchronously) forces all reset values, including clearing any pending pulse. The first accepted instruction is at the first rising edge after `rst` deasserts.
- `stall` and `halt` in the same cycle: `stall` wins and HALT is not entered.
- Inputs are sampled only at the rising edge. Combinational next-PC logic has no path to outputs other than through registers.

## Test plan
- Reset then 3 unstalled cycles, no jump → `pc` = 0, 4, 8, C; `instr_count`=3; `redirect`=0.
- At `pc`=8: `validJump`=1, `target_sel`=0, `offset`=−8 → next cycle `pc`=0, `redirect`=1 for one cycle, `link_we`=0.
- At `pc`=0x10: `validJump`=1, `target_sel`=1, `reg_target`=0x100, `is_call`=1 → `pc`=0x100, `link_we`=1, `link_addr`=0x14.
- `stall`=1 for 2 cycles with `validJump`=1, then release → `pc` and `instr_count` hold for 2 cycles; the jump is taken only after release.
- `reg_target`=0x102 taken → `fault`=1, `pc` frozen. Later `halt`/`validJump` have no effect; `rst` restores `pc`=RESET_PC and `fault`=0.
- `halt`=1 and `validJump`=1 together at `pc`=0x20 → `halted`=1, `pc` stays 0x20, `instr_count`+1. Separately, `pc`=0xFFFF_FFFC sequential → `pc`=0.
